// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//
// Debounced push-button front end. The raw pins are normalised so that
// 1 means pressed, passed through a 2-flop synchroniser, and then debounced
// per channel by an independent FSM. Each channel reports a clean level plus
// single-cycle press, release and long-press (hold) strobes.
//
// Parameters
//   WIDTH        number of button channels
//   DEB_CYCLES   consecutive stable synchronised cycles needed to accept a change (>=1)
//   HOLD_CYCLES  cycles from the press strobe to the hold strobe; 0 disables hold
//   ACTIVE_LOW   1: pin reads 0 when pressed, 0: pin reads 1 when pressed
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   btn_i          raw asynchronous button pins
//   btn_level_o    debounced pressed state (1 = pressed)
//   btn_press_o    1-cycle strobe on an accepted press
//   btn_release_o  1-cycle strobe on an accepted release
//   btn_hold_o     1-cycle strobe, once per press, HOLD_CYCLES after the press
//
// Per-channel FSM
//   state           | meaning
//   ----------------+----------------------------------------------------
//   ST_RELEASED     | stable released; waiting for a pressed sample
//   ST_PRESS_WAIT   | pressed samples seen, counting toward DEB_CYCLES
//   ST_PRESSED      | stable pressed; hold counter running until hold fires
//   ST_RELEASE_WAIT | released samples seen, counting; hold counter frozen
// -----------------------------------------------------------------------------
module button_reader #(
   parameter int WIDTH       = 4,
   parameter int DEB_CYCLES  = 100000,
   parameter int HOLD_CYCLES = 10000000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] btn_i,
   output logic [WIDTH-1:0] btn_level_o,
   output logic [WIDTH-1:0] btn_press_o,
   output logic [WIDTH-1:0] btn_release_o,
   output logic [WIDTH-1:0] btn_hold_o
);

   localparam int DEB_W_RAW  = $clog2(DEB_CYCLES + 1);
   localparam int DEB_W      = (DEB_W_RAW < 1) ? 1 : DEB_W_RAW;
   localparam int HOLD_W_RAW = $clog2(HOLD_CYCLES + 1);
   localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;

   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam bit                HOLD_EN  = (HOLD_CYCLES > 0);

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   logic [WIDTH-1:0]  pressed;
   logic [WIDTH-1:0]  sync1_q;
   logic [WIDTH-1:0]  sync2_q;

   state_t            state_q [WIDTH];
   state_t            state_d [WIDTH];
   logic [DEB_W-1:0]  deb_q   [WIDTH];
   logic [DEB_W-1:0]  deb_d   [WIDTH];
   logic [HOLD_W-1:0] hold_q  [WIDTH];
   logic [HOLD_W-1:0] hold_d  [WIDTH];
   logic [WIDTH-1:0]  hold_done_q;
   logic [WIDTH-1:0]  hold_done_d;

   logic [WIDTH-1:0]  level_d;
   logic [WIDTH-1:0]  press_d;
   logic [WIDTH-1:0]  release_d;
   logic [WIDTH-1:0]  hold_stb_d;

   assign pressed = btn_i ^ {WIDTH{ACTIVE_LOW}};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         hold_done_q   <= '0;
         btn_level_o   <= '0;
         btn_press_o   <= '0;
         btn_release_o <= '0;
         btn_hold_o    <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_RELEASED;
            deb_q[i]   <= '0;
            hold_q[i]  <= '0;
         end
      end else begin
         sync1_q       <= pressed;
         sync2_q       <= sync1_q;
         hold_done_q   <= hold_done_d;
         btn_level_o   <= level_d;
         btn_press_o   <= press_d;
         btn_release_o <= release_d;
         btn_hold_o    <= hold_stb_d;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            deb_q[i]   <= deb_d[i];
            hold_q[i]  <= hold_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i]     = state_q[i];
         deb_d[i]       = deb_q[i];
         hold_d[i]      = hold_q[i];
         hold_done_d[i] = hold_done_q[i];
         level_d[i]     = btn_level_o[i];
         press_d[i]     = 1'b0;
         release_d[i]   = 1'b0;
         hold_stb_d[i]  = 1'b0;

         case (state_q[i])
            ST_RELEASED: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_PRESS_WAIT;
                  deb_d[i]   = DEB_ONE;
               end else begin
                  deb_d[i]   = '0;
               end
            end

            ST_PRESS_WAIT: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_RELEASED;
                  deb_d[i]   = '0;
               end else if (deb_q[i] == DEB_MAX) begin
                  state_d[i]     = ST_PRESSED;
                  level_d[i]     = 1'b1;
                  press_d[i]     = 1'b1;
                  hold_d[i]      = '0;
                  hold_done_d[i] = 1'b0;
               end else begin
                  deb_d[i] = deb_q[i] + DEB_ONE;
               end
            end

            ST_PRESSED: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_RELEASE_WAIT;
                  deb_d[i]   = DEB_ONE;
               end
               // Counting still happens on the edge that leaves for
               // RELEASE_WAIT; only cycles spent in RELEASE_WAIT delay hold.
               if (HOLD_EN && !hold_done_q[i]) begin
                  hold_d[i] = hold_q[i] + HOLD_ONE;
                  if ((hold_q[i] + HOLD_ONE) == HOLD_MAX) begin
                     hold_stb_d[i]  = 1'b1;
                     hold_done_d[i] = 1'b1;
                  end
               end
            end

            ST_RELEASE_WAIT: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_PRESSED;
               end else if (deb_q[i] == DEB_MAX) begin
                  state_d[i]   = ST_RELEASED;
                  level_d[i]   = 1'b0;
                  release_d[i] = 1'b1;
               end else begin
                  deb_d[i] = deb_q[i] + DEB_ONE;
               end
            end

            default: begin
               state_d[i] = ST_RELEASED;
               deb_d[i]   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_reader.sv
module tb_button_reader;

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic [3:0] level;
   logic [3:0] press;
   logic [3:0] rel;
   logic [3:0] hold;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] hold;
   } ev_t;

   ev_t sb[$];

   button_reader #(
      .WIDTH      (4),
      .DEB_CYCLES (4),
      .HOLD_CYCLES(20),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .btn_i        (btn),
      .btn_level_o  (level),
      .btn_press_o  (press),
      .btn_release_o(rel),
      .btn_hold_o   (hold)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Expected strobes for one cycle; entries for the same cycle are merged.
   function automatic void expect_ev(int c, logic [3:0] p, logic [3:0] r, logic [3:0] h);
      ev_t e;
      int  idx  = sb.size();
      bit  done = 1'b0;
      for (int i = 0; i < sb.size(); i++) begin
         if (!done && sb[i].cyc == c) begin
            e       = sb[i];
            e.press = e.press | p;
            e.rel   = e.rel | r;
            e.hold  = e.hold | h;
            sb[i]   = e;
            done    = 1'b1;
         end else if (!done && sb[i].cyc > c && idx == sb.size()) begin
            idx = i;
         end
      end
      if (!done) begin
         e.cyc   = c;
         e.press = p;
         e.rel   = r;
         e.hold  = h;
         sb.insert(idx, e);
      end
   endfunction

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic monitor();
      ev_t e;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         chk("press_strobe", press, e.press);
         chk("release_strobe", rel, e.rel);
         chk("hold_strobe", hold, e.hold);
      end else begin
         checks++;
         assert ({press, rel, hold} === 12'h000) else begin
            failures++;
            $error("FAIL quiet cyc=%0d observed press=%b release=%b hold=%b expected all 0",
                   cyc, press, rel, hold);
         end
      end
   endtask

   task automatic tick(int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         monitor();
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 4'b0000;          // all pressed (active low)
      tick(3);
      chk("reset_level", level, 4'b0000);
      chk("reset_press", press, 4'b0000);
      chk("reset_release", rel, 4'b0000);
      chk("reset_hold", hold, 4'b0000);

      // Release reset with everything pressed: treated as a fresh press.
      rst = 1'b0;
      expect_ev(cyc + 7, 4'b1111, 4'b0000, 4'b0000);
      expect_ev(cyc + 27, 4'b0000, 4'b0000, 4'b1111);
      tick(8);
      chk("level_after_reset_press", level, 4'b1111);
      tick(22);
      btn = 4'b1111;
      expect_ev(cyc + 7, 4'b0000, 4'b1111, 4'b0000);
      tick(10);
      chk("level_all_released", level, 4'b0000);

      // Clean press/release on bit 0 held for 30 cycles.
      btn[0] = 1'b0;
      expect_ev(cyc + 7, 4'b0001, 4'b0000, 4'b0000);
      expect_ev(cyc + 27, 4'b0000, 4'b0000, 4'b0001);
      tick(6);
      chk("level0_before_latency", level, 4'b0000);
      tick(24);
      chk("level0_pressed", level, 4'b0001);
      btn[0] = 1'b1;
      expect_ev(cyc + 7, 4'b0000, 4'b0001, 4'b0000);
      tick(6);
      chk("level0_before_release", level, 4'b0001);
      tick(30);
      chk("level0_released", level, 4'b0000);

      // Bounce on bit 1: never stable for 4 synchronised cycles.
      btn[1] = 1'b0; tick(3);
      btn[1] = 1'b1; tick(1);
      btn[1] = 1'b0; tick(2);
      btn[1] = 1'b1; tick(10);
      chk("level1_bounce", level, 4'b0000);

      // Bit 2: short release bounce at hold count 10 delays hold by 2.
      btn[2] = 1'b0;
      expect_ev(cyc + 7, 4'b0100, 4'b0000, 4'b0000);
      expect_ev(cyc + 29, 4'b0000, 4'b0000, 4'b0100);
      tick(14);
      btn[2] = 1'b1; tick(2);
      btn[2] = 1'b0; tick(10);
      chk("level2_through_bounce", level, 4'b0100);
      tick(20);
      btn[2] = 1'b1;
      expect_ev(cyc + 7, 4'b0000, 4'b0100, 4'b0000);
      tick(12);
      chk("level2_released", level, 4'b0000);

      // Bit 3 pressed, then bit 0 press and bit 3 release on the same edge.
      btn[3] = 1'b0;
      expect_ev(cyc + 7, 4'b1000, 4'b0000, 4'b0000);
      expect_ev(cyc + 27, 4'b0000, 4'b0000, 4'b1000);
      tick(30);
      btn[0] = 1'b0;
      btn[3] = 1'b1;
      expect_ev(cyc + 7, 4'b0001, 4'b1000, 4'b0000);
      expect_ev(cyc + 27, 4'b0000, 4'b0000, 4'b0001);
      tick(8);
      chk("level_swap", level, 4'b0001);
      tick(22);
      btn[0] = 1'b1;
      expect_ev(cyc + 7, 4'b0000, 4'b0001, 4'b0000);
      tick(10);

      // Bit 1 pressed, then reset mid-press: level drops at once, no release.
      btn[1] = 1'b0;
      expect_ev(cyc + 7, 4'b0010, 4'b0000, 4'b0000);
      tick(10);
      chk("level1_pressed", level, 4'b0010);
      rst = 1'b1;
      #1;
      chk("level1_async_clear", level, 4'b0000);
      chk("release1_async_clear", rel, 4'b0000);
      tick(3);
      rst = 1'b0;
      expect_ev(cyc + 7, 4'b0010, 4'b0000, 4'b0000);
      expect_ev(cyc + 27, 4'b0000, 4'b0000, 4'b0010);
      tick(30);
      chk("level1_repressed", level, 4'b0010);
      btn[1] = 1'b1;
      expect_ev(cyc + 7, 4'b0000, 4'b0010, 4'b0000);
      tick(12);
      chk("level_final", level, 4'b0000);

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
